knn_data_responder: RTL and testbench

- Memory-side responder for knn_system's read/read_done and write/write_done handshakes.
- Holds the training set, the training labels and the input sample in internal word memory, which the host loads before a run.
- On read, streams every word to the classifier's loader, one word per cycle, then pulses read_done.
- On write, captures L sorted (distance, type) results, then pulses write_done. The host reads the results back through a random-access port.

---
 rtl/knn_data_responder.sv | 167 ++++++++++++++++
 tb/tb_knn_data_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/knn_data_responder.sv
// Memory-side responder for knn_system: streams the stored training set, labels and
// input sample on read, and captures the sorted (distance, type) results on write.
module knn_data_responder #(
   parameter  int M  = 2,
   parameter  int N  = 3,
   parameter  int W  = 32,
   parameter  int L  = 15,
   localparam int D  = L*M*N + L + M*N,
   localparam int AW = $clog2(D),
   localparam int RW = $clog2(L)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          read,
   output logic          read_done,
   input  logic          write,
   output logic          write_done,
   output logic          data_valid,
   output logic [AW-1:0] data_addr,
   output logic [W-1:0]  data_out,
   input  logic          res_valid,
   input  logic [W-1:0]  res_dist,
   input  logic [W-1:0]  res_type,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [W-1:0]  load_data,
   input  logic [RW-1:0] res_rd_addr,
   output logic [W-1:0]  res_rd_dist,
   output logic [W-1:0]  res_rd_type,
   output logic          busy
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SEND  = 3'd1;
   localparam logic [2:0] ST_RDONE = 3'd2;
   localparam logic [2:0] ST_RWAIT = 3'd3;
   localparam logic [2:0] ST_RECV  = 3'd4;
   localparam logic [2:0] ST_WDONE = 3'd5;
   localparam logic [2:0] ST_WWAIT = 3'd6;

   localparam logic [AW-1:0] LAST_WORD = AW'(D - 1);
   localparam logic [RW-1:0] LAST_RES  = RW'(L - 1);

   logic [W-1:0] data_mem [D];
   logic [W-1:0] dist_mem [L];
   logic [W-1:0] type_mem [L];

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          data_valid_q, data_valid_d;
   logic [AW-1:0] data_addr_q, data_addr_d;
   logic [W-1:0]  data_out_q, data_out_d;
   logic          read_done_q, read_done_d;
   logic          write_done_q, write_done_d;

   logic          load_we;
   logic          res_we;
   logic [AW-1:0] cnt_inc;
   logic [W-1:0]  first_word;

   assign load_we = (state_q == ST_IDLE) && load_en && (load_addr < AW'(D));
   assign res_we  = (state_q == ST_RECV) && res_valid;
   assign cnt_inc = cnt_q + AW'(1);

   // Word 0 is launched on the same edge a host load may write it, so forward that load.
   assign first_word = (load_we && (load_addr == '0)) ? load_data : data_mem[0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rcnt_d       = rcnt_q;
      data_valid_d = 1'b0;
      data_addr_d  = data_addr_q;
      data_out_d   = data_out_q;
      read_done_d  = 1'b0;
      write_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (read) begin
               state_d      = ST_SEND;
               cnt_d        = '0;
               data_valid_d = 1'b1;
               data_addr_d  = '0;
               data_out_d   = first_word;
            end else if (write) begin
               state_d = ST_RECV;
               rcnt_d  = '0;
            end
         end
         ST_SEND: begin
            if (cnt_q == LAST_WORD) begin
               state_d     = ST_RDONE;
               read_done_d = 1'b1;
            end else begin
               cnt_d        = cnt_inc;
               data_valid_d = 1'b1;
               data_addr_d  = cnt_inc;
               data_out_d   = data_mem[cnt_inc];
            end
         end
         ST_RDONE: state_d = ST_RWAIT;
         ST_RWAIT: begin
            if (!read) state_d = ST_IDLE;
         end
         ST_RECV: begin
            if (res_valid) begin
               if (rcnt_q == LAST_RES) begin
                  state_d      = ST_WDONE;
                  write_done_d = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
         end
         ST_WDONE: state_d = ST_WWAIT;
         ST_WWAIT: begin
            if (!write) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rcnt_q       <= '0;
         data_valid_q <= 1'b0;
         data_addr_q  <= '0;
         data_out_q   <= '0;
         read_done_q  <= 1'b0;
         write_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rcnt_q       <= rcnt_d;
         data_valid_q <= data_valid_d;
         data_addr_q  <= data_addr_d;
         data_out_q   <= data_out_d;
         read_done_q  <= read_done_d;
         write_done_q <= write_done_d;
      end
   end

   // Storage is deliberately outside the reset domain so a reset never loses loaded data.
   always_ff @(posedge clk) begin
      if (load_we) begin
         data_mem[load_addr] <= load_data;
      end
      if (res_we) begin
         dist_mem[rcnt_q] <= res_dist;
         type_mem[rcnt_q] <= res_type;
      end
   end

   assign res_rd_dist = (res_rd_addr < RW'(L)) ? dist_mem[res_rd_addr] : '0;
   assign res_rd_type = (res_rd_addr < RW'(L)) ? type_mem[res_rd_addr] : '0;

   assign data_valid = data_valid_q;
   assign data_addr  = data_addr_q;
   assign data_out   = data_out_q;
   assign read_done  = read_done_q;
   assign write_done = write_done_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_knn_data_responder.sv
// Self-checking bench for knn_data_responder: a word/result memory model plus a
// per-cycle compare process, driven by directed and randomized transactions.
`timescale 1ns/1ps
module tb_knn_data_responder;

   localparam int M  = 2;
   localparam int N  = 3;
   localparam int W  = 32;
   localparam int L  = 15;
   localparam int D  = L*M*N + L + M*N;
   localparam int AW = $clog2(D);
   localparam int RW = $clog2(L);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          read, write, res_valid, load_en;
   logic [W-1:0]  res_dist, res_type, load_data;
   logic [AW-1:0] load_addr;
   logic [RW-1:0] res_rd_addr;
   logic          read_done, write_done, data_valid, busy;
   logic [AW-1:0] data_addr;
   logic [W-1:0]  data_out, res_rd_dist, res_rd_type;

   knn_data_responder #(.M(M), .N(N), .W(W), .L(L)) dut (
      .clk(clk), .rst(rst), .read(read), .read_done(read_done),
      .write(write), .write_done(write_done), .data_valid(data_valid),
      .data_addr(data_addr), .data_out(data_out), .res_valid(res_valid),
      .res_dist(res_dist), .res_type(res_type), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .res_rd_addr(res_rd_addr),
      .res_rd_dist(res_rd_dist), .res_rd_type(res_rd_type), .busy(busy)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_fail = 0;
   int           exp_addr = 0;
   int           wd_count = 0;
   int           wd_expected = 0;
   bit           chk_on = 1'b0;
   logic [W-1:0] model_mem  [D];
   logic [W-1:0] seen_word  [D];
   logic [W-1:0] model_dist [L];
   logic [W-1:0] model_type [L];
   bit           res_known  [L];

   task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stream words must be consecutive from 0 and match the model; results must match once written.
   always @(negedge clk) begin
      if (rst && chk_on) begin
         if (data_valid) begin
            check_output("stream_addr", W'(data_addr), W'(exp_addr));
            if (int'(data_addr) < D) begin
               check_output("stream_data", data_out, model_mem[data_addr]);
               seen_word[data_addr] = data_out;
            end
            exp_addr++;
            if (read_done) check_output("done_during_stream", W'(read_done), W'(0));
         end else begin
            exp_addr = 0;
         end
         if (write_done) wd_count++;
         if (int'(res_rd_addr) < L && res_known[res_rd_addr]) begin
            check_output("res_rd_dist", res_rd_dist, model_dist[res_rd_addr]);
            check_output("res_rd_type", res_rd_type, model_type[res_rd_addr]);
         end
      end
   end

   task automatic apply_stimulus(input int addr, input logic [W-1:0] val);
      load_en   = 1'b1;
      load_addr = AW'(addr);
      load_data = val;
      step();
      load_en = 1'b0;
      if (addr < D) model_mem[addr] = val;
   endtask

   task automatic run_read(input int hold_extra, input int load_at);
      int n = 0;
      read = 1'b1;
      step();
      while (data_valid === 1'b1 && n < D + 20) begin
         if (n == load_at) begin
            load_en   = 1'b1;
            load_addr = AW'(5);
            load_data = 32'hDEAD;
         end else begin
            load_en = 1'b0;
         end
         n++;
         step();
      end
      load_en = 1'b0;
      check_output("stream_len", W'(n), W'(D));
      check_output("read_done_pulse", W'(read_done), W'(1));
      check_output("valid_after_stream", W'(data_valid), W'(0));
      step();
      check_output("read_done_width", W'(read_done), W'(0));
      for (int i = 0; i < hold_extra; i++) begin
         check_output("no_retrigger", W'(data_valid), W'(0));
         check_output("busy_rwait", W'(busy), W'(1));
         step();
      end
      read = 1'b0;
      step();
      check_output("idle_after_read", W'(busy), W'(0));
   endtask

   task automatic run_write(input bit rand_mode);
      int           k = 0;
      int           cyc = 0;
      bit           v;
      logic [W-1:0] dv, tv;
      write = 1'b1;
      step();
      check_output("busy_recv", W'(busy), W'(1));
      while (k < L && cyc < 400) begin
         v  = rand_mode ? ($urandom_range(0, 2) != 0) : (cyc % 2 == 0);
         dv = rand_mode ? W'($urandom) : W'(k * 10);
         tv = rand_mode ? W'($urandom) : W'(k % 4);
         res_valid   = v;
         res_dist    = dv;
         res_type    = tv;
         res_rd_addr = RW'($urandom_range(0, L - 1));
         step();
         cyc++;
         if (v) begin
            model_dist[k] = dv;
            model_type[k] = tv;
            res_known[k]  = 1'b1;
            k++;
            check_output("write_done_timing", W'(write_done), W'(k == L));
         end else begin
            check_output("write_done_stall", W'(write_done), W'(0));
         end
      end
      res_valid = 1'b0;
      check_output("captures", W'(k), W'(L));
      step();
      check_output("write_done_width", W'(write_done), W'(0));
      check_output("busy_wwait", W'(busy), W'(1));
      write = 1'b0;
      step();
      check_output("idle_after_write", W'(busy), W'(0));
      wd_expected++;
   endtask

   task automatic check_reset_outputs();
      check_output("rst_data_valid", W'(data_valid), W'(0));
      check_output("rst_data_addr", W'(data_addr), W'(0));
      check_output("rst_data_out", data_out, W'(0));
      check_output("rst_read_done", W'(read_done), W'(0));
      check_output("rst_write_done", W'(write_done), W'(0));
      check_output("rst_busy", W'(busy), W'(0));
   endtask

   initial begin
      read = 1'b0; write = 1'b0; res_valid = 1'b0; load_en = 1'b0;
      res_dist = '0; res_type = '0; load_addr = '0; load_data = '0; res_rd_addr = '0;
      for (int i = 0; i < L; i++) res_known[i] = 1'b0;

      #2 rst = 1'b0;
      #1 check_reset_outputs();
      step();
      step();
      rst = 1'b1;
      chk_on = 1'b1;

      for (int a = 0; a < D; a++) apply_stimulus(a, W'(a * 3));
      run_read(6, -1);
      check_output("pin_word0", seen_word[0], W'(0));
      check_output("pin_word37", seen_word[37], W'(111));
      check_output("pin_word110", seen_word[110], W'(330));

      run_write(1'b0);
      res_rd_addr = RW'(14);
      #1;
      check_output("pin_res14_dist", res_rd_dist, W'(140));
      check_output("pin_res14_type", res_rd_type, W'(2));

      write = 1'b1;
      run_read(2, -1);
      run_write(1'b0);

      res_valid = 1'b1; res_dist = W'(99); res_type = W'(99); res_rd_addr = '0;
      step();
      step();
      res_valid = 1'b0;
      check_output("idle_res_busy", W'(busy), W'(0));
      check_output("pin_res0_dist", res_rd_dist, W'(0));
      res_rd_addr = RW'(9);
      #1;
      check_output("pin_res9_dist", res_rd_dist, W'(90));
      check_output("pin_res9_type", res_rd_type, W'(1));

      run_read(0, 10);
      apply_stimulus(120, W'(77));
      run_read(0, -1);
      check_output("pin_word5_after_send_load", seen_word[5], W'(15));

      read = 1'b1;
      step();
      repeat (40) step();
      check_output("mid_send_addr", W'(data_addr), W'(40));
      rst = 1'b0;
      #1 check_reset_outputs();
      read = 1'b0;
      step();
      rst = 1'b1;
      step();
      run_read(1, -1);
      check_output("pin_word5_after_reset", seen_word[5], W'(15));

      repeat (5) begin
         repeat (8) apply_stimulus(int'($urandom_range(0, D + 10)), W'($urandom));
         if ($urandom_range(0, 1) == 1) run_read(int'($urandom_range(0, 3)), -1);
         else run_write(1'b1);
      end
      run_read(0, -1);

      check_output("write_done_count", W'(wd_count), W'(wd_expected));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
